serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around the existing 1-bit full adder `addbit`.
- Per clock it adds one bit pair, LSB first, and keeps the carry in a flip-flop between bits.
- Start/done handshake: operands are captured on start; sum and carry-out are presented as registered results when done.
- Sits directly downstream of `addbit` as its consumer; trades latency for area in multi-bit datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits (>= 2).
- COUNT_W, 4, bit-counter width; must satisfy 2^COUNT_W > WIDTH.

Ports:
- clk    input   1      rising-edge clock
- reset  input   1      asynchronous, active-high reset
- start  input   1      request; sampled only in IDLE or DONE
- a      input   WIDTH  operand A, captured on accepted start
- b      input   WIDTH  operand B, captured on accepted start
- ci     input   1      carry-in, captured on accepted start
- busy   output  1      high while in SHIFT
- done   output  1      one-cycle pulse; result valid
- sum    output  WIDTH  registered sum, held until next completion
- co     output  1      registered carry-out, held until next completion

Behaviour:
- Reset (asynchronous, active-high) forces the following, taking effect immediately:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, co = 0
  - shift registers, carry flip-flop and counter cleared
- FSM states and transitions:
  - IDLE: start=1 loads a_sr<=a, b_sr<=b, carry<=ci, cnt<=0, and moves to SHIFT.
  - SHIFT: each edge does the following:
    - Feeds a_sr[0], b_sr[0] and carry into `addbit`.
    - Shifts a_sr and b_sr right by one.
    - Shifts the addbit sum into the s_sr MSB, right-shifting s_sr.
    - Sets carry <= addbit co and cnt <= cnt+1.
    - When cnt==WIDTH-1, this edge also copies the completed s_sr into sum and the final carry into co, and moves to DONE.
  - DONE: done=1 for exactly one cycle, then the next edge does one of two things:
    - start=1: reloads exactly as in IDLE and moves to SHIFT (back-to-back operation).
    - start=0: moves to IDLE.
- Latency: start sampled at edge E0 gives bit i processed at edge E(i+1); done is high in the cycle after edge E(WIDTH).
  - Throughput is one add per WIDTH+1 cycles.
- Arithmetic: {co,sum} = a + b + ci, modulo 2^(WIDTH+1); no sign interpretation.
- Boundary conditions:
  - start while in SHIFT is ignored; the operation in flight is unaffected.
  - Operand input changes after capture have no effect.
  - sum/co change only on the completion edge; intermediate bits are never visible on sum.
  - reset mid-SHIFT aborts: no done pulse, sum/co cleared.
  - busy and done are never high together.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port `ovf` (1 bit), registered and reset to 0.
  - On the completion edge, ovf <= (carry into MSB) XOR (carry out of MSB), i.e. the two's-complement signed overflow.
  - ovf holds alongside sum.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared include file `serial_adder_defs.vh` holds:
  - the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default WIDTH and COUNT_W values.
- Sub-module: one `addbit` instance for the per-bit sum and carry; no new sub-module.
- The control FSM stays inline.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h33, ci=0, pulse start -> busy for 8 cycles, done pulse in the 9th cycle after the start edge, sum=8'h8D, co=0.
- a=8'hFF, b=8'h00, ci=1 -> sum=8'h00, co=1.
  - a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1.
- Start 8'h01+8'h01, then assert start with a=b=8'hFF during SHIFT -> second request ignored; sum=8'h02, co=0, exactly one done pulse.
- Hold start=1 continuously, alternating operands each accepted start (8'h10+8'h20, then 8'h7F+8'h01) -> done every 9 cycles, with results 8'h30 then 8'h80.
- Assert reset at the 4th SHIFT cycle of 8'hAA+8'h55 -> busy=0, sum=0, co=0 immediately; no done pulse; the next start completes normally.
- With SERIAL_ADDER_OVF_EN defined:
  - 8'h7F+8'h01 -> sum=8'h80, co=0, ovf=1.
  - 8'hFF+8'h01 -> sum=8'h00, co=1, ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for serial_adder: control state encodings and default sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_COUNT_W = 4;

endpackage

// File: rtl/addbit.sv
// 1-bit full adder used as the per-bit engine of serial_adder.
module addbit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    always_comb begin
        sum = a ^ b ^ ci;
        co  = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through addbit.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned COUNT_W = DEFAULT_COUNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_e state_q, state_d;

    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic [WIDTH-2:0]   s_sr_q;
    logic [COUNT_W-1:0] cnt_q;
    logic               carry_q;

    logic               bit_sum;
    logic               bit_co;
    logic               load;
    logic               shift_en;
    logic               last;
    logic [WIDTH-1:0]   s_next;

    addbit u_addbit (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .ci  (carry_q),
        .sum (bit_sum),
        .co  (bit_co)
    );

    always_comb begin
        load     = start && ((state_q == StIdle) || (state_q == StDone));
        shift_en = (state_q == StShift);
        last     = shift_en && (cnt_q == COUNT_W'(WIDTH - 1));
        // Collected bits so far plus the bit produced on this edge.
        s_next   = {bit_sum, s_sr_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last) state_d = StDone;
            StDone:  state_d = start ? StShift : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= ci;
            cnt_q   <= '0;
        end else if (shift_en) begin
            a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
            s_sr_q  <= s_next[WIDTH-1:1];
            carry_q <= bit_co;
            cnt_q   <= cnt_q + COUNT_W'(1);
        end
    end

    // Results move only on the completion edge so partial sums never show.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
            co  <= 1'b0;
        end else if (last) begin
            sum <= s_next;
            co  <= bit_co;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last bit carry_q is the carry into the MSB, bit_co the carry out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= carry_q ^ bit_co;
        end
    end
`endif

endmodule
